msg_serialiser: RTL and testbench

//  Packet-to-word serialiser: the transmit-side counterpart of the UART message assembler.

---
 rtl/msg_serialiser.sv | 129 ++++++++++++
 tb/tb_msg_serialiser.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/msg_serialiser.sv
// Packet-to-word serialiser feeding uart_tx: accepts one packet on valid/ready and
// emits it as WORDS_PER_PACKET words, each with a one-cycle start pulse.
module msg_serialiser #(
  parameter int WORD_SIZE        = 8,
  parameter int WORDS_PER_PACKET = 4,
  parameter bit MSB_FIRST        = 1'b1,
  parameter int GAP_CLKS         = 0
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [WORD_SIZE*WORDS_PER_PACKET-1:0] pkt_in,
  input  logic                                  pkt_valid,
  output logic                                  pkt_ready,
  input  logic                                  uart_ready,
  output logic [WORD_SIZE-1:0]                  data_out,
  output logic                                  data_out_req,
  output logic                                  busy
);

  localparam int PW    = WORD_SIZE * WORDS_PER_PACKET;
  localparam int CNT_W = $clog2(WORDS_PER_PACKET);
  localparam int GAP_W = (GAP_CLKS > 1) ? $clog2(GAP_CLKS) : 1;

  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WORDS_PER_PACKET - 1);
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'((GAP_CLKS > 0) ? GAP_CLKS - 1 : 0);

  generate
    if (WORDS_PER_PACKET < 2) begin : g_bad_words
      $error("msg_serialiser: WORDS_PER_PACKET must be at least 2");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_HOLD,
    S_WAIT,
    S_GAP
  } state_t;

  state_t             state;
  logic [PW-1:0]      shift_q;
  logic [CNT_W-1:0]   word_cnt;
  logic [GAP_W-1:0]   gap_cnt;

  logic [WORD_SIZE-1:0] cur_word;
  logic [PW-1:0]        shift_next;

  // The outgoing word always sits at one fixed end of the shift register.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    cur_word   = '0;
    shift_next = shift_q;
    if (MSB_FIRST) begin
      cur_word   = shift_q[PW-1 -: WORD_SIZE];
      shift_next = shift_q << WORD_SIZE;
    end else begin
      cur_word   = shift_q[WORD_SIZE-1:0];
      shift_next = shift_q >> WORD_SIZE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      shift_q      <= '0;
      word_cnt     <= '0;
      gap_cnt      <= '0;
      pkt_ready    <= 1'b0;
      data_out     <= '0;
      data_out_req <= 1'b0;
      busy         <= 1'b0;
    end else begin
      data_out_req <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (pkt_valid && pkt_ready) begin
            shift_q   <= pkt_in;
            word_cnt  <= '0;
            pkt_ready <= 1'b0;
            busy      <= 1'b1;
            state     <= S_SEND;
          end else begin
            pkt_ready <= 1'b1;
          end
        end
        S_SEND: begin
          if (uart_ready) begin
            data_out     <= cur_word;
            data_out_req <= 1'b1;
            state        <= S_HOLD;
          end
        end
        // uart_tx is still registering the start pulse; its ready is stale here.
        S_HOLD: state <= S_WAIT;
        S_WAIT: begin
          if (uart_ready) begin
            if (word_cnt == LAST_WORD) begin
              if (GAP_CLKS == 0) begin
                pkt_ready <= 1'b1;
                busy      <= 1'b0;
                state     <= S_IDLE;
              end else begin
                gap_cnt <= '0;
                state   <= S_GAP;
              end
            end else begin
              shift_q  <= shift_next;
              word_cnt <= word_cnt + 1'b1;
              state    <= S_SEND;
            end
          end
        end
        S_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            pkt_ready <= 1'b1;
            busy      <= 1'b0;
            state     <= S_IDLE;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_msg_serialiser.sv
// Bench for msg_serialiser: two instances (MSB-first/no gap, LSB-first/5-clock gap),
// a randomized uart_tx responder, and a scoreboard of expected words per instance.
module tb_msg_serialiser;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pkt_in     [2];
  logic        pkt_valid  [2];
  logic        pkt_ready  [2];
  logic        uart_ready [2];
  logic [7:0]  data_out   [2];
  logic        data_out_req [2];
  logic        busy       [2];
  logic        stall      [2];
  int          ucnt       [2];
  logic [7:0]  exp_q      [2][$];
  int          words_sent [2];
  bit          fixed_delay;
  int          tests  = 0;
  int          failed = 0;

  always #5 clk = ~clk;

  msg_serialiser #(.WORD_SIZE(8), .WORDS_PER_PACKET(4), .MSB_FIRST(1'b1), .GAP_CLKS(0)) u_msb (
    .clk(clk), .reset(reset), .pkt_in(pkt_in[0]), .pkt_valid(pkt_valid[0]),
    .pkt_ready(pkt_ready[0]), .uart_ready(uart_ready[0]), .data_out(data_out[0]),
    .data_out_req(data_out_req[0]), .busy(busy[0]));

  msg_serialiser #(.WORD_SIZE(8), .WORDS_PER_PACKET(4), .MSB_FIRST(1'b0), .GAP_CLKS(5)) u_lsb (
    .clk(clk), .reset(reset), .pkt_in(pkt_in[1]), .pkt_valid(pkt_valid[1]),
    .pkt_ready(pkt_ready[1]), .uart_ready(uart_ready[1]), .data_out(data_out[1]),
    .data_out_req(data_out_req[1]), .busy(busy[1]));

  // uart_tx stand-in: goes busy for a while after each start pulse.
  assign uart_ready[0] = (ucnt[0] == 0) && !stall[0];
  assign uart_ready[1] = (ucnt[1] == 0) && !stall[1];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      ucnt[0] <= 0;
      ucnt[1] <= 0;
    end else begin
      for (int g = 0; g < 2; g++) begin
        if (data_out_req[g]) ucnt[g] <= fixed_delay ? 10 : int'($urandom_range(12, 1));
        else if (ucnt[g] > 0) ucnt[g] <= ucnt[g] - 1;
      end
    end
  end

  function automatic int gap_of(input int g);
    return (g == 0) ? 0 : 5;
  endfunction

  task automatic check(input string name, input int g, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s[inst%0d] at %0t: got %0h, expected %0h", name, g, $time, act, exp);
    end
  endtask

  // Reference: word i of a packet is byte (3-i) for MSB-first, byte i otherwise.
  task automatic push_pkt(input int g, input logic [31:0] p);
    for (int i = 0; i < 4; i++) begin
      int sh;
      sh = (g == 0) ? 8 * (3 - i) : 8 * i;
      exp_q[g].push_back(8'((p >> sh) & 32'hFF));
    end
  endtask

  // Called at a negedge; returns at the negedge after acceptance.
  task automatic send_pkt(input int g, input logic [31:0] p, input int junk_cycles);
    int n;
    n = 0;
    pkt_in[g]    = p;
    pkt_valid[g] = 1'b1;
    while (!pkt_ready[g] && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("accept_in_time", g, 32'(n < 2000), 1);
    if (n < 2000) begin
      push_pkt(g, p);
      @(negedge clk);
      for (int i = 0; i < junk_cycles; i++) begin
        pkt_in[g] = $urandom;
        @(negedge clk);
      end
    end
    pkt_valid[g] = 1'b0;
  endtask

  task automatic wait_idle(input int g);
    int n;
    n = 0;
    while (!(exp_q[g].size() == 0 && pkt_ready[g]) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("drain_in_time", g, 32'(n < 5000), 1);
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string name);
    for (int g = 0; g < 2; g++) begin
      check({name, "_pkt_ready"}, g, pkt_ready[g], 0);
      check({name, "_data_out"}, g, data_out[g], 0);
      check({name, "_req"}, g, data_out_req[g], 0);
      check({name, "_busy"}, g, busy[g], 0);
    end
  endtask

  // Monitor: pops the scoreboard on every start pulse and times the post-packet gap.
  initial begin
    int         pops      [2];
    int         phase     [2];
    int         gap_left  [2];
    logic       prev_req  [2];
    logic [7:0] last_word [2];
    for (int g = 0; g < 2; g++) begin
      pops[g] = 0; phase[g] = 0; gap_left[g] = 0; prev_req[g] = 1'b0; last_word[g] = '0;
      words_sent[g] = 0;
    end
    forever begin
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
        if (reset) begin
          pops[g] = 0; phase[g] = 0; gap_left[g] = 0; prev_req[g] = 1'b0; last_word[g] = '0;
        end else begin
          if (phase[g] == 2) begin
            if (uart_ready[g]) begin
              gap_left[g] = gap_of(g);
              phase[g] = 3;
            end
          end else if (phase[g] == 3) begin
            if (gap_left[g] > 0) begin
              check("gap_pkt_ready_low", g, pkt_ready[g], 0);
              check("gap_busy_high", g, busy[g], 1);
              gap_left[g]--;
            end else begin
              check("ready_after_gap", g, pkt_ready[g], 1);
              check("busy_clear_after_gap", g, busy[g], 0);
              phase[g] = 0;
            end
          end
          if (data_out_req[g]) begin
            check("req_single_cycle", g, prev_req[g], 0);
            check("req_expected", g, 32'(exp_q[g].size() != 0), 1);
            if (exp_q[g].size() != 0) begin
              logic [7:0] w;
              w = exp_q[g].pop_front();
              check("word", g, data_out[g], w);
              last_word[g] = w;
              words_sent[g]++;
              pops[g]++;
              if (pops[g] == 4) begin
                pops[g] = 0;
                phase[g] = 2;
              end
            end
          end else begin
            check("data_out_hold", g, data_out[g], last_word[g]);
          end
          prev_req[g] = data_out_req[g];
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d failed so far", failed);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int bad;
    int base;
    int n;
    reset       = 1'b1;
    fixed_delay = 1'b1;
    for (int g = 0; g < 2; g++) begin
      pkt_in[g] = '0; pkt_valid[g] = 1'b0; stall[g] = 1'b0;
    end

    repeat (3) @(negedge clk);
    check_reset_outputs("in_reset");
    reset = 1'b0;
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      check("ready_one_clk_after_release", g, pkt_ready[g], 1);
      check("idle_not_busy", g, busy[g], 0);
    end

    // Directed: fixed 10-clock uart, MSB-first and LSB-first order, back-to-back with gap.
    send_pkt(0, 32'hA1B2C3D4, 3);
    wait_idle(0);
    send_pkt(1, 32'hA1B2C3D4, 3);
    send_pkt(1, 32'h5A6B7C8D, 0);
    wait_idle(1);

    // Randomized traffic on both instances at once.
    fixed_delay = 1'b0;
    fork
      begin
        for (int k = 0; k < 12; k++) begin
          repeat ($urandom_range(3, 0)) @(negedge clk);
          send_pkt(0, $urandom, int'($urandom_range(4, 0)));
        end
        wait_idle(0);
      end
      begin
        for (int k = 0; k < 8; k++) begin
          repeat ($urandom_range(3, 0)) @(negedge clk);
          send_pkt(1, $urandom, int'($urandom_range(4, 0)));
        end
        wait_idle(1);
      end
    join

    // uart_ready held low after accept: no start pulse, still busy.
    stall[0] = 1'b1;
    base = words_sent[0];
    send_pkt(0, $urandom, 0);
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (data_out_req[0] || !busy[0]) bad++;
    end
    check("stall_quiet_cycles", 0, bad, 0);
    check("stall_no_words", 0, words_sent[0] - base, 0);
    stall[0] = 1'b0;
    n = 0;
    while (words_sent[0] == base && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("word_after_stall_release", 0, words_sent[0] - base, 1);
    wait_idle(0);

    // Reset after the second word: partial packet is dropped, next packet is clean.
    base = words_sent[0];
    send_pkt(0, $urandom, 0);
    n = 0;
    while (words_sent[0] < base + 2 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("two_words_before_reset", 0, words_sent[0] - base, 2);
    #2 reset = 1'b1;
    #1 check_reset_outputs("async_reset");
    exp_q[0].delete();
    exp_q[1].delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("ready_after_midpkt_reset", 0, pkt_ready[0], 1);
    base = words_sent[0];
    send_pkt(0, 32'h11223344, 6);
    wait_idle(0);
    check("words_after_reset", 0, words_sent[0] - base, 4);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
